// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package imem_loader_pkg;

    localparam int INSTR_W = 32;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - big-endian byte-to-word packer for the loader
//
// Holds the leading bytes of the word being assembled plus a 2-bit byte
// counter. The word is presented as o_word_next, which is the value the
// 4-byte window holds once the byte currently on i_byte is shifted in, so
// the loader can capture a complete word on the same edge that accepts
// its last byte.
//
// Ports:
//   i_clk        clock
//   i_reset      synchronous active-high reset
//   i_clear      start of a new load: drop any partial word
//   i_shift      a byte is accepted this cycle
//   i_byte       incoming byte (most-significant byte of a word first)
//   o_word_next  assembled word including i_byte
//   o_word_full  the byte accepted this cycle completes a word
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_shift,
    input  logic [BYTE_W-1:0]  i_byte,
    output logic [INSTR_W-1:0] o_word_next,
    output logic               o_word_full
);

    // Only the three leading bytes need storage; the fourth byte of the
    // window is the live input lane.
    logic [INSTR_W-BYTE_W-1:0] r_buf;
    logic [1:0]                r_cnt;

    assign o_word_next = {r_buf, i_byte};
    assign o_word_full = i_shift && (r_cnt == 2'd3);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_buf <= o_word_next[INSTR_W-BYTE_W-1:0];
            r_cnt <= r_cnt + 2'd1;   // wraps to 0 after the fourth byte
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a byte stream as 32-bit words into instruction memory
//
// A legal start latches word_count, then bytes are collected four at a
// time (most-significant first) and each complete word is written to
// consecutive addresses from 0. done pulses after the last write; an
// illegal word_count (0 or above DEPTH) pulses error and nothing else.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to keep a running XOR of
// the words written in the current load on checksum; otherwise checksum
// is constant 0.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, word_count   load request and word count (sampled together)
//   byte_valid/byte_data/byte_ready   byte stream handshake
//   mem_we/mem_addr/mem_wdata         instruction-memory write port
//   busy, done, error   load status
//   checksum            XOR of words written in this load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W:0]    word_count,
    input  logic               byte_valid,
    input  logic [BYTE_W-1:0]  byte_data,
    output logic               byte_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [INSTR_W-1:0] checksum
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

    state_t               r_state;
    logic [ADDR_W:0]      r_count;
    logic [ADDR_W:0]      r_idx;
    logic                 r_byte_ready;
    logic                 r_mem_we;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [INSTR_W-1:0]   r_mem_wdata;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;

    logic                 w_accept;
    logic                 w_count_ok;
    logic                 w_clear;
    logic [ADDR_W:0]      w_idx_next;
    logic [INSTR_W-1:0]   w_word_next;
    logic                 w_word_full;

    assign w_accept   = r_byte_ready && byte_valid;
    assign w_count_ok = (word_count != '0) && (word_count <= DEPTH_W);
    assign w_clear    = (r_state == IDLE) && start && w_count_ok;
    assign w_idx_next = r_idx + IDX_ONE;

    byte_packer u_packer (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_clear     (w_clear),
        .i_shift     (w_accept),
        .i_byte      (byte_data),
        .o_word_next (w_word_next),
        .o_word_full (w_word_full)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0] r_checksum;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_idx        <= '0;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_checksum   <= '0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_count_ok) begin
                            r_count      <= word_count;
                            r_idx        <= '0;
                            r_busy       <= 1'b1;
                            r_byte_ready <= 1'b1;
                            r_state      <= COLLECT;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_checksum   <= '0;
`endif
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    // The last byte and the write port are captured on the
                    // same edge, so WRITE presents a complete word at once.
                    if (w_word_full) begin
                        r_byte_ready <= 1'b0;
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= r_idx[ADDR_W-1:0];
                        r_mem_wdata  <= w_word_next;
                        r_state      <= WRITE;
                    end
                end
                WRITE: begin
                    r_idx <= w_idx_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    r_checksum <= r_checksum ^ r_mem_wdata;
`endif
                    if (w_idx_next == r_count) begin
                        r_done  <= 1'b1;
                        r_state <= FINISH;
                    end else begin
                        r_byte_ready <= 1'b1;
                        r_state      <= COLLECT;
                    end
                end
                FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign byte_ready = r_byte_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   word_count = '0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic [31:0]       checksum;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int n_done = 0;
    int n_error = 0;
    int done_base = 0;
    int err_base = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    int                wr_cyc[$];
    logic [7:0]        stim[$];
    int                gaps[$];
    logic [31:0]       exp_w[$];

    typedef struct {
        int          cnt;
        int          nbytes;
        logic [63:0] stream;
        bit          exp_err;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (error) n_error++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_base = n_done;
        err_base  = n_error;
    endtask

    task automatic start_pulse(input int cnt);
        start_cyc  = cyc;
        start      = 1'b1;
        word_count = cnt[ADDR_W:0];
        tick();
        start      = 1'b0;
    endtask

    // Feeds stim[] with gaps[i] idle cycles before byte i; optionally raises
    // start (count 1) while byte start_at is on offer.
    task automatic feed(input int start_at);
        bit acc;
        int guard;
        for (int i = 0; i < stim.size(); i++) begin
            if (i < gaps.size()) begin
                byte_valid = 1'b0;
                repeat (gaps[i]) tick();
            end
            byte_valid = 1'b1;
            byte_data  = stim[i];
            guard = 0;
            acc = 1'b0;
            while (!acc && guard < 50) begin
                if (i == start_at && guard == 0) begin
                    start = 1'b1;
                    word_count = 1;
                end
                @(negedge clk);
                acc = byte_ready;
                tick();
                start = 1'b0;
                guard++;
            end
            if (!acc) begin
                check($sformatf("byte_accept_timeout_%0d", i), 0, 1);
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        while (n_done == done_base && g < 200) begin
            tick();
            g++;
        end
        repeat (3) tick();
        check({tag, "_done_count"}, n_done - done_base, 1);
    endtask

    task automatic verify(input string tag);
        logic [31:0] ck = '0;
        check({tag, "_nwrites"}, wr_data.size(), exp_w.size());
        for (int i = 0; i < exp_w.size(); i++) begin
            ck ^= exp_w[i];
            if (i < wr_data.size()) begin
                check($sformatf("%s_addr%0d", tag, i), wr_addr[i], i);
                check($sformatf("%s_data%0d", tag, i), wr_data[i], exp_w[i]);
            end
        end
`ifndef IMEM_LOADER_CHECKSUM_EN
        ck = '0;
`endif
        check({tag, "_checksum"}, checksum, ck);
        check({tag, "_busy_idle"}, busy, 0);
        if (wr_cyc.size() > 0)
            check({tag, "_done_latency"}, done_cyc, wr_cyc[wr_cyc.size()-1] + 1);
        if (exp_w.size() > 0) begin
            check({tag, "_addr_hold"}, mem_addr, exp_w.size() - 1);
            check({tag, "_data_hold"}, mem_wdata, exp_w[exp_w.size()-1]);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{cnt: 1,  nbytes: 4, stream: 64'hE211_0000_0000_0000, exp_err: 0, w0: 32'hE2110000, w1: 32'h0};
        vecs[1] = '{cnt: 2,  nbytes: 8, stream: 64'hE080_5183_E7D1_2000, exp_err: 0, w0: 32'hE0805183, w1: 32'hE7D12000};
        vecs[2] = '{cnt: 0,  nbytes: 0, stream: 64'h0,                   exp_err: 1, w0: 32'h0,        w1: 32'h0};
        vecs[3] = '{cnt: 17, nbytes: 0, stream: 64'h0,                   exp_err: 1, w0: 32'h0,        w1: 32'h0};
        vecs[4] = '{cnt: 1,  nbytes: 4, stream: 64'h1AFF_FFFD_0000_0000, exp_err: 0, w0: 32'h1AFFFFFD, w1: 32'h0};
        vecs[5] = '{cnt: 2,  nbytes: 8, stream: 64'hDEAD_BEEF_0123_4567, exp_err: 0, w0: 32'hDEADBEEF, w1: 32'h01234567};

        // Reset state
        repeat (3) tick();
        check("rst_byte_ready", byte_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_checksum", checksum, 0);
        reset = 1'b0;
        tick();

        // Table vectors, back-to-back bytes
        for (int v = 0; v < 6; v++) begin
            string tag;
            logic [63:0] s;
            tag = $sformatf("vec%0d", v);
            clear_log();
            stim.delete();
            gaps.delete();
            exp_w.delete();
            s = vecs[v].stream;
            for (int b = 0; b < vecs[v].nbytes; b++) stim.push_back(s[63-8*b -: 8]);
            if (vecs[v].exp_err) begin
                start_pulse(vecs[v].cnt);
                check({tag, "_error_pulse"}, error, 1);
                check({tag, "_busy_low"}, busy, 0);
                tick();
                check({tag, "_error_one_cycle"}, error, 0);
                repeat (3) tick();
                check({tag, "_error_count"}, n_error - err_base, 1);
                check({tag, "_no_write"}, wr_data.size(), 0);
                check({tag, "_still_idle"}, busy, 0);
            end else begin
                exp_w.push_back(vecs[v].w0);
                if (vecs[v].cnt > 1) exp_w.push_back(vecs[v].w1);
                start_pulse(vecs[v].cnt);
                check({tag, "_busy"}, busy, 1);
                feed(-1);
                wait_done(tag);
                verify(tag);
                for (int i = 0; i < wr_cyc.size(); i++)
                    check($sformatf("%s_throughput%0d", tag, i), wr_cyc[i] - start_cyc, 5 * (i + 1));
            end
        end

        // Stall: three idle cycles between the second and third byte
        clear_log();
        stim = '{8'hE2, 8'h11, 8'h00, 8'h00};
        gaps = '{0, 0, 3, 0};
        exp_w = '{32'hE2110000};
        start_pulse(1);
        feed(-1);
        wait_done("stall");
        verify("stall");
        if (wr_cyc.size() > 0) check("stall_latency", wr_cyc[0] - start_cyc, 8);

        // Reset after two bytes, then a clean single-word load
        clear_log();
        stim = '{8'hAA, 8'hBB};
        gaps.delete();
        start_pulse(1);
        feed(-1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_byte_ready", byte_ready, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_mem_wdata", mem_wdata, 0);
        check("midrst_checksum", checksum, 0);
        tick();
        check("midrst_no_write", wr_data.size(), 0);
        clear_log();
        stim = '{8'h1A, 8'hFF, 8'hFF, 8'hFD};
        exp_w = '{32'h1AFFFFFD};
        start_pulse(1);
        feed(-1);
        wait_done("postrst");
        verify("postrst");

        // Full depth with a start issued while busy
        clear_log();
        stim.delete();
        exp_w.delete();
        for (int w = 0; w < DEPTH; w++) begin
            logic [31:0] word;
            word = $urandom;
            exp_w.push_back(word);
            for (int b = 3; b >= 0; b--) stim.push_back(word[8*b +: 8]);
        end
        start_pulse(DEPTH);
        feed(20);
        wait_done("full");
        verify("full");
        repeat (10) tick();
        check("full_no_extra_write", wr_data.size(), DEPTH);
        check("full_no_error", n_error - err_base, 0);

        // Randomised loads against the word model
        for (int r = 0; r < 6; r++) begin
            int cnt;
            string tag;
            tag = $sformatf("rnd%0d", r);
            cnt = $urandom_range(1, DEPTH);
            clear_log();
            stim.delete();
            gaps.delete();
            exp_w.delete();
            for (int w = 0; w < cnt; w++) begin
                logic [31:0] word;
                word = $urandom;
                exp_w.push_back(word);
                for (int b = 3; b >= 0; b--) begin
                    stim.push_back(word[8*b +: 8]);
                    gaps.push_back($urandom_range(0, 2));
                end
            end
            start_pulse(cnt);
            feed(-1);
            wait_done(tag);
            verify(tag);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
